// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide-unit sequencer: command
// encodings, FSM state type and the default multiplier latency.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_MTHI  = 2'b10;
  localparam logic [1:0] MDU_MTLO  = 2'b11;

  localparam int MDU_MUL_LATENCY = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq_if.sv
// Execute-stage <-> multiply sequencer bus: command in, status and HI/LO out.
interface mdu_seq_if;
  import mdu_pkg::*;

  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_seq_mult.sv
// Combinational 32x32 -> 64 multiplier, signed or unsigned by sign_flag.
// Its inputs come only from the sequencer's operand registers, so the whole
// block sits on a multicycle path.
module mdu_seq_mult (
  input  logic        sign_flag,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        sa;
  logic        sb;
  logic [63:0] prod;

  assign sa = sign_flag & a[31];
  assign sb = sign_flag & b[31];

  // Extending both operands to 64 bits and keeping the low 64 bits of the
  // product gives the exact result for both signed and unsigned cases.
  assign prod = $signed({{32{sa}}, a}) * $signed({{32{sb}}, b});

  assign hi = prod[63:32];
  assign lo = prod[31:0];

endmodule

// File: rtl/mdu_seq.sv
// Multiply sequencer and architectural HI/LO holder. Latches operands on a
// MULT/MULTU command, holds them for MUL_LATENCY cycles while the multiplier
// settles, then commits the product. MTHI/MTLO write HI/LO directly.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MUL_LATENCY = MDU_MUL_LATENCY,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  mdu_seq_if.slave    bus
);

  generate
    if (MUL_LATENCY < 1 || MUL_LATENCY >= (1 << CNT_W)) begin : g_bad_latency
      $error("mdu_seq: MUL_LATENCY out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

  mdu_state_t       state_q;
  mdu_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic             sgn_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             done_q;
  logic             accept;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic [31:0]      mul_hi;
  logic [31:0]      mul_lo;

  mdu_seq_mult u_mult (
    .sign_flag (sgn_q),
    .a         (opa_q),
    .b         (opb_q),
    .hi        (mul_hi),
    .lo        (mul_lo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and command decode; cancel beats both accept and commit.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            MDU_MTHI: wr_hi = 1'b1;
            MDU_MTLO: wr_lo = 1'b1;
            default: begin
              accept  = 1'b1;
              state_d = RUN;
            end
          endcase
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and latency countdown; operands stay frozen while in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      opa_q <= bus.a;
      opb_q <= bus.b;
      sgn_q <= bus.op[0];
      cnt_q <= CNT_INIT;
    end else if (state_q == RUN && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Architectural HI/LO and the registered one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= mul_hi;
        lo_q <= mul_lo;
      end else begin
        if (wr_hi) hi_q <= bus.a;
        if (wr_lo) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with hand-computed HI/LO results.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  mdu_seq_if bus ();

  mdu_seq #(.MUL_LATENCY(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply, then count busy cycles and check the commit.
  task automatic run_mul(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int n;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      step();
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd4);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    check({tag, " done_drop"}, 64'(bus.done), 64'd0);
  endtask

  task automatic mt(input logic [1:0] op, input logic [31:0] a);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = MDU_MULTU;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    #12;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    step();

    run_mul("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("mult_min2", MDU_MULT, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000);
    run_mul("mult_m1m1", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_mul("mult_m3x5", MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_mul("multu_m3x5", MDU_MULTU, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1);

    // Back-to-back MTHI then MTLO.
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.a     = 32'h1234_5678;
    step();
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi done", 64'(bus.done), 64'd0);
    bus.op = MDU_MTLO;
    bus.a  = 32'h9ABC_DEF0;
    step();
    bus.start = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo hi_kept", 64'(bus.hi), 64'h1234_5678);
    check("mtlo busy", 64'(bus.busy), 64'd0);
    check("mtlo done", 64'(bus.done), 64'd0);
    step();
    check("mt idle done", 64'(bus.done), 64'd0);

    // start together with cancel in IDLE is dropped.
    bus.start  = 1'b1;
    bus.op     = MDU_MTHI;
    bus.a      = 32'h0000_0055;
    bus.cancel = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("idle_cancel hi", 64'(bus.hi), 64'h1234_5678);
    check("idle_cancel busy", 64'(bus.busy), 64'd0);

    // Start during RUN is ignored.
    begin
      int n;
      bus.start = 1'b1;
      bus.op    = MDU_MULTU;
      bus.a     = 32'd3;
      bus.b     = 32'd5;
      step();
      bus.start = 1'b0;
      step();
      bus.start = 1'b1;
      bus.op    = MDU_MTHI;
      bus.a     = 32'h0000_DEAD;
      step();
      bus.start = 1'b0;
      check("ignore hi_mid", 64'(bus.hi), 64'h1234_5678);
      n = 2;
      while (bus.busy && n < 20) begin
        n++;
        step();
      end
      check("ignore busy_cycles", 64'(n), 64'd4);
      check("ignore done", 64'(bus.done), 64'd1);
      check("ignore hi", 64'(bus.hi), 64'd0);
      check("ignore lo", 64'(bus.lo), 64'd15);
      step();
      check("ignore idle", 64'(bus.busy), 64'd0);
    end

    // Cancel on the commit cycle.
    mt(MDU_MTHI, 32'hAAAA_AAAA);
    mt(MDU_MTLO, 32'hAAAA_AAAA);
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.a     = 32'd7;
    bus.b     = 32'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    check("cancel busy_pre", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel done", 64'(bus.done), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'hAAAA_AAAA);
    check("cancel lo", 64'(bus.lo), 64'hAAAA_AAAA);
    step();
    check("cancel done_after", 64'(bus.done), 64'd0);

    // Asynchronous reset mid-RUN.
    bus.start = 1'b1;
    bus.op    = MDU_MULTU;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    step();
    bus.start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", 64'(bus.busy), 64'd0);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst hi", 64'(bus.hi), 64'd0);
    check("arst lo", 64'(bus.lo), 64'd0);
    #1;
    rst = 1'b0;
    step();
    check("arst no_commit", 64'(bus.done), 64'd0);
    run_mul("post_rst", MDU_MULTU, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
